fifo_sc_stream_rd: RTL

Read-side drain for the single-clock generic FIFO. It issues `fifo_re`, absorbs the FIFO's one-cycle registered-read latency, and presents the popped words as a valid/ready stream at full rate. A 2-entry skid buffer keeps the stream at one word per cycle even when the consumer stalls. It sits between the FIFO read port and any streaming consumer, and shares the FIFO's `clk` and `clr`.

---
 rtl/fifo_pkg.sv | 9 +
 rtl/fifo_skid2.sv | 53 +++++
 rtl/fifo_sc_stream_rd.sv | 58 +++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and types for the single-clock FIFO read-side drain.
package fifo_pkg;
  localparam int FIFO_SKID_DEPTH = 2;
  localparam int OCC_W = $clog2(FIFO_SKID_DEPTH + 1);

  typedef logic [OCC_W-1:0] occ_t;
  // One extra bit so occupancy plus an in-flight read cannot wrap.
  typedef logic [OCC_W:0]   pend_t;
endpackage

// File: rtl/fifo_skid2.sv
// Two-entry skid buffer: slot0 is the head, slot1 absorbs one word of consumer stall.
module fifo_skid2
  import fifo_pkg::*;
#(
  parameter int dw = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [dw-1:0] i_data,
  input  logic          i_pop,
  output logic [dw-1:0] o_head,
  output logic          o_valid,
  output occ_t          o_occ
);
  logic [dw-1:0] r_slot0;
  logic [dw-1:0] r_slot1;
  occ_t          r_occ;
  logic          r_valid;
  occ_t          w_occ_after_pop;
  occ_t          w_occ_next;

  assign w_occ_after_pop = r_occ - occ_t'(i_pop);

  always_comb begin
    w_occ_next = w_occ_after_pop + occ_t'(i_push);
    if (i_flush) w_occ_next = '0;
  end

  // A pushed word lands in the first slot left free after this cycle's pop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_occ   <= '0;
      r_valid <= 1'b0;
      r_slot0 <= '0;
    end else begin
      r_occ   <= w_occ_next;
      r_valid <= (w_occ_next != '0);
      if (!i_flush) begin
        if (i_pop && (r_occ == occ_t'(FIFO_SKID_DEPTH))) r_slot0 <= r_slot1;
        if (i_push) begin
          if (w_occ_after_pop == '0) r_slot0 <= i_data;
          else                       r_slot1 <= i_data;
        end
      end
    end
  end

  assign o_head  = r_slot0;
  assign o_valid = r_valid;
  assign o_occ   = r_occ;
endmodule

// File: rtl/fifo_sc_stream_rd.sv
// Drains a registered-read FIFO into a full-rate valid/ready stream through a 2-entry skid buffer.
module fifo_sc_stream_rd
  import fifo_pkg::*;
#(
  parameter int dw = 8,
  parameter int cw = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_fifo_empty,
  input  logic [dw-1:0] i_fifo_dout,
  output logic          o_fifo_re,
  output logic          o_out_valid,
  output logic [dw-1:0] o_out_data,
  input  logic          i_out_ready,
  output logic [cw-1:0] o_words_out,
  output logic          o_busy
);
  logic          r_inflight;
  logic [cw-1:0] r_words_out;
  occ_t          w_occ;
  logic          w_pop;
  pend_t         w_pending;

  assign w_pop = o_out_valid & i_out_ready;

  // Words already committed to the buffer once this cycle's pop retires.
  assign w_pending = pend_t'(w_occ) + pend_t'(r_inflight) - pend_t'(w_pop);
  assign o_fifo_re = !i_rst & !i_clr & !i_fifo_empty &
                     (w_pending < pend_t'(FIFO_SKID_DEPTH));

  fifo_skid2 #(.dw(dw)) u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_clr),
    .i_push  (r_inflight),
    .i_data  (i_fifo_dout),
    .i_pop   (w_pop),
    .o_head  (o_out_data),
    .o_valid (o_out_valid),
    .o_occ   (w_occ)
  );

  // clr leaves the counter alone; the in-flight word is dropped because the FIFO clears too.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_inflight  <= 1'b0;
      r_words_out <= '0;
    end else begin
      r_inflight <= o_fifo_re;
      if (w_pop) r_words_out <= r_words_out + cw'(1);
    end
  end

  assign o_words_out = r_words_out;
  assign o_busy      = r_inflight | (w_occ != '0);
endmodule
